// File: rtl/uart_receiver_sipo.sv
// Oversampling UART receiver: start detect, mid-bit sampling, MSB-first shift,
// parity/stop checking, and a one-cycle rx_done strobe per received byte.
module uart_receiver_sipo #(
  parameter int FIFO_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                  Rx_clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  rx_done,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(FIFO_WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FIFO_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic                    armed_q, armed_d;
  logic [FIFO_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_bit_q, par_bit_d;
  logic [FIFO_WIDTH-1:0]   dout_q, dout_d;
  logic                    rx_done_q, rx_done_d;
  logic                    parity_err_q, parity_err_d;
  logic                    frame_err_q, frame_err_d;

  function automatic logic calc_parity_err(input logic [FIFO_WIDTH-1:0] data,
                                           input logic par);
    return (^data) ^ par ^ (PARITY_ODD != 0);
  endfunction

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge Rx_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bitcnt_q     <= '0;
      armed_q      <= 1'b1;
      dout_q       <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bitcnt_q     <= bitcnt_d;
      armed_q      <= armed_d;
      dout_q       <= dout_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge Rx_clk) begin
    shreg_q   <= shreg_d;
    par_bit_q <= par_bit_d;
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + 1'b1;
    bitcnt_d     = bitcnt_q;
    armed_d      = armed_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    dout_d       = dout_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          if (!rx_s_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_q == TICK_END) begin
          tick_d   = '0;
          shreg_d  = {shreg_q[FIFO_WIDTH-2:0], rx_s_q};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (tick_q == TICK_END) begin
          tick_d    = '0;
          par_bit_d = rx_s_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        // A low stop bit disarms start detection until the line has been seen high.
        if (tick_q == TICK_END) begin
          tick_d       = '0;
          dout_d       = shreg_q;
          rx_done_d    = 1'b1;
          parity_err_d = calc_parity_err(shreg_q, par_bit_q);
          frame_err_d  = ~rx_s_q;
          armed_d      = rx_s_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout       = dout_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);

endmodule
